mc_control_fsm: RTL and testbench

- Multi-cycle MIPS main controller. Sequences the shared datapath (single ALU, single unified memory, IR, A/B/ALUOut/MDR registers) through fetch/decode/execute/memory/writeback steps per instruction.
- Supports R-format (0), lw (35), sw (43), beq (4), j (2) and addi (8).
- Stalls on a memory-ready handshake.
- Counts retired instructions and flags illegal opcodes.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mc_retire_counter.sv | 24 ++
 rtl/mc_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// opcodes, FSM states, ALU and mux select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// Wrapping count of retired instructions.
// Increments once per enabled clock edge.
module mc_retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences the shared datapath
// per instruction, stalls on mem_ready, counts retirements.
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t r_state;

    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic       w_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            unique case (r_state)
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW,
                        OP_SW:    r_state <= S_MEMADR;
                        OP_RTYPE: r_state <= S_EXEC;
                        OP_BEQ:   r_state <= S_BRANCH;
                        OP_J:     r_state <= S_JUMP;
                        OP_ADDI:  r_state <= S_ADDIEX;
                        default:  r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ADDIWB: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_regwrite    = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 1'b0;
        PCSource      = PCS_ALU;
        ALUOp         = ALU_ADD;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        RegDst        = 1'b0;
        w_illegal     = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_IMMSH;
                w_illegal = !op_supported(op);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                IorD      = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                MemtoReg   = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                IorD       = 1'b1;
                w_retire   = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                RegDst     = 1'b1;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                w_pcwritecond = 1'b1;
                PCSource      = PCS_ALUOUT;
                w_retire      = 1'b1;
            end
            S_JUMP: begin
                w_pcwrite = 1'b1;
                PCSource  = PCS_JUMP;
                w_retire  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            default: begin
                w_retire = 1'b0;
            end
        endcase
    end

    // Reset forces strobes low in the same cycle; mux selects
    // already read FETCH because the state register clears async.
    assign PCWrite     = w_pcwrite & rst_n;
    assign PCWriteCond = w_pcwritecond & rst_n;
    assign MemRead     = w_memread & rst_n;
    assign MemWrite    = w_memwrite & rst_n;
    assign IRWrite     = w_irwrite & rst_n;
    assign RegWrite    = w_regwrite & rst_n;
    assign illegal_op  = w_illegal & rst_n;
    assign state       = r_state;

    mc_retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_retire),
        .o_count (retired)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a spec-level model pushes
// expected per-cycle outputs, compared on the falling edge.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic        MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [3:0]  state;
    logic        illegal_op;
    logic [15:0] retired;

    logic        w2_pcw, w2_pcwc, w2_iord, w2_mrd, w2_mwr;
    logic        w2_m2r, w2_irw, w2_sa, w2_rw, w2_rd, w2_ill;
    logic [1:0]  w2_pcs, w2_aop, w2_sb;
    logic [3:0]  w2_state;
    logic [1:0]  w2_ret;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .state(state), .illegal_op(illegal_op),
        .retired(retired)
    );

    // Narrow counter copy exercises the wrap from all-ones to zero.
    mc_control_fsm #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCWrite(w2_pcw), .PCWriteCond(w2_pcwc), .IorD(w2_iord),
        .MemRead(w2_mrd), .MemWrite(w2_mwr), .MemtoReg(w2_m2r),
        .IRWrite(w2_irw), .PCSource(w2_pcs), .ALUOp(w2_aop),
        .ALUSrcA(w2_sa), .ALUSrcB(w2_sb), .RegWrite(w2_rw),
        .RegDst(w2_rd), .state(w2_state), .illegal_op(w2_ill),
        .retired(w2_ret)
    );

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [5:0] stb;
        logic [9:0] mux;
        logic       ill;
        logic [15:0] ret;
        logic [1:0] retw;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;
    logic [3:0]  m_st = 4'd0;
    logic [15:0] m_ret = 16'd0;
    logic [1:0]  m_retw = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] o);
        return o == 6'd0 || o == 6'd2 || o == 6'd4 ||
               o == 6'd8 || o == 6'd35 || o == 6'd43;
    endfunction

    // {PCWrite,PCWriteCond,MemRead,MemWrite,IRWrite,RegWrite} and
    // {IorD,MemtoReg,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegDst}.
    function automatic logic [15:0] model_ctl(input logic [3:0] s,
                                              input logic mr);
        logic pw, pwc, mrd, mwr, irw, rw, iord, m2r, sa, rd;
        logic [1:0] pcs, aop, sb;
        {pw, pwc, mrd, mwr, irw, rw, iord, m2r, sa, rd} = '0;
        pcs = 2'b00; aop = 2'b00; sb = 2'b00;
        case (s)
            4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            4'd9:  begin pw = 1; pcs = 2'b10; end
            4'd10: begin sa = 1; sb = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, mrd, mwr, irw, rw, iord, m2r, pcs, aop, sa, sb, rd};
    endfunction

    function automatic logic [3:0] model_next(input logic [3:0] s,
                                              input logic [5:0] o,
                                              input logic mr);
        case (s)
            4'd0: return mr ? 4'd1 : 4'd0;
            4'd1: begin
                if (o == 6'd35 || o == 6'd43) return 4'd2;
                if (o == 6'd0) return 4'd6;
                if (o == 6'd4) return 4'd8;
                if (o == 6'd2) return 4'd9;
                if (o == 6'd8) return 4'd10;
                return 4'd0;
            end
            4'd2:  return (o == 6'd35) ? 4'd3 : 4'd5;
            4'd3:  return mr ? 4'd4 : 4'd3;
            4'd5:  return mr ? 4'd0 : 4'd5;
            4'd6:  return 4'd7;
            4'd10: return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    task automatic compare(input exp_t e);
        chk({e.tag, ".state"}, 32'(state), 32'(e.st));
        chk({e.tag, ".strobes"},
            32'({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite}),
            32'(e.stb));
        chk({e.tag, ".muxes"},
            32'({IorD, MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegDst}),
            32'(e.mux));
        chk({e.tag, ".illegal"}, 32'(illegal_op), 32'(e.ill));
        chk({e.tag, ".retired"}, 32'(retired), 32'(e.ret));
        chk({e.tag, ".retired2"}, 32'(w2_ret), 32'(e.retw));
    endtask

    // Called at posedge+1: drive, predict, compare at negedge, advance.
    task automatic cyc(input string tag, input logic [5:0] o,
                       input logic mr);
        exp_t e;
        logic [15:0] c;
        op = o;
        mem_ready = mr;
        c = model_ctl(m_st, mr);
        e.tag = tag; e.st = m_st; e.stb = c[15:10]; e.mux = c[9:0];
        e.ill = (m_st == 4'd1) && !legal(o);
        e.ret = m_ret; e.retw = m_retw;
        q.push_back(e);
        @(negedge clk);
        compare(q.pop_front());
        if (m_st inside {4'd4, 4'd7, 4'd8, 4'd9, 4'd11} ||
            (m_st == 4'd5 && mr)) begin
            m_ret++;
            m_retw++;
        end
        m_st = model_next(m_st, o, mr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        exp_t e;
        e.tag = tag; e.st = 4'd0; e.stb = 6'd0; e.mux = 10'b0000000010;
        e.ill = 1'b0; e.ret = 16'd0; e.retw = 2'd0;
        q.push_back(e);
        compare(q.pop_front());
    endtask

    task automatic run_instr(input string tag, input logic [5:0] o,
                             input int n);
        for (int i = 0; i < n; i++) cyc(tag, o, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        m_st = 4'd0; m_ret = '0; m_retw = '0;
        @(posedge clk);
        #1;

        run_instr("lw", 6'd35, 5);
        chk("lw_retired", 32'(retired), 32'd1);

        cyc("fstall", 6'd0, 1'b0);
        cyc("fstall", 6'd0, 1'b0);
        run_instr("rtype", 6'd0, 4);

        run_instr("sw", 6'd43, 3);
        for (int i = 0; i < 3; i++) cyc("sw_wait", 6'd43, 1'b0);
        cyc("sw_done", 6'd43, 1'b1);

        run_instr("r", 6'd0, 4);
        run_instr("beq", 6'd4, 3);
        run_instr("j", 6'd2, 3);
        run_instr("addi", 6'd8, 4);
        chk("seq_retired", 32'(retired), 32'd7);

        run_instr("illegal", 6'd63, 2);
        chk("ill_retired", 32'(retired), 32'd7);

        run_instr("j_wrap", 6'd2, 3);
        chk("wrap2", 32'(w2_ret), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] tbl [7];
            tbl = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43, 6'd21};
            cyc("rand", tbl[$urandom_range(0, 6)],
                1'($urandom_range(0, 1)));
        end

        while (m_st != 4'd0) cyc("drain", 6'd35, 1'b1);
        run_instr("lw_rst", 6'd35, 3);
        cyc("memrd_wait", 6'd35, 1'b0);
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk_reset("async_rst");
        m_st = 4'd0; m_ret = '0; m_retw = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst", 6'd35, 1'b1);
        run_instr("post_rst_lw", 6'd35, 4);
        chk("post_rst_retired", 32'(retired), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
